// File: rtl/debounce_bit.sv
// One debounced input: two-flop synchroniser, tick-qualified stability counter,
// registered level, one-cycle edge pulses and a sticky change flag.
module debounce_bit #(
  parameter int   STABLE_TICKS = 10,
  parameter logic RST_VAL      = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_pin,
  input  logic i_ack,
  output logic o_state,
  output logic o_rise,
  output logic o_fall,
  output logic o_changed
);

  localparam int               CNT_W    = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             s1_p1;
  logic             s2_p2;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  // Qualification completes on the tick that sees the last stable count.
  assign flip = i_tick && (s2_p2 != o_state) && (cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_p1     <= RST_VAL;
      s2_p2     <= RST_VAL;
      cnt       <= '0;
      o_state   <= RST_VAL;
      o_rise    <= 1'b0;
      o_fall    <= 1'b0;
      o_changed <= 1'b0;
    end else begin
      // stage p1/p2: metastability synchroniser
      s1_p1 <= i_pin;
      s2_p2 <= s1_p1;

      // stage p3: stability counter and debounced level
      if (s2_p2 == o_state) begin
        cnt <= '0;
      end else if (i_tick) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
      if (flip) begin
        o_state <= ~o_state;
      end
      o_rise <= flip & ~o_state;
      o_fall <= flip &  o_state;

      // stage p4: sticky flag; a fresh edge beats a simultaneous ack
      if (o_rise || o_fall) begin
        o_changed <= 1'b1;
      end else if (i_ack) begin
        o_changed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/nexys_input_debounce.sv
// Debouncer and change detector for the Nexys A7 switches/buttons feeding the
// SweRVolf GPIO input bus; shared tick prescaler plus one debounce_bit per input.
module nexys_input_debounce #(
  parameter int               WIDTH        = 16,
  parameter int               TICK_DIV     = 50_000,
  parameter int               STABLE_TICKS = 10,
  parameter logic [WIDTH-1:0] RST_VAL      = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_pins,
  input  logic [WIDTH-1:0] i_irq_en,
  input  logic [WIDTH-1:0] i_ack,
  output logic [WIDTH-1:0] o_state,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic [WIDTH-1:0] o_changed,
  output logic             o_irq
);

  localparam int                PCNT_W    = $clog2(TICK_DIV);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);

  logic [PCNT_W-1:0] pcnt;
  logic              tick;

  assign tick = (pcnt == PCNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS (STABLE_TICKS),
      .RST_VAL      (RST_VAL[i])
    ) u_bit (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_tick    (tick),
      .i_pin     (i_pins[i]),
      .i_ack     (i_ack[i]),
      .o_state   (o_state[i]),
      .o_rise    (o_rise[i]),
      .o_fall    (o_fall[i]),
      .o_changed (o_changed[i])
    );
  end

  // stage p5: interrupt follows the registered sticky flags by one cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= |(o_changed & i_irq_en);
    end
  end

endmodule
